ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  2  per-requester access request, bit i = requester i.
REQ-006 SHALL have port we  input  2  per-requester write enable (1 = write, 0 = read).
REQ-007 SHALL have port addr  input  2*ADDR_W  requester i address in bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port wdata  input  2*DATA_W  requester i write data in bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port gnt  output  2  one-cycle grant pulse, one-hot or zero.
REQ-010 SHALL have port rvalid  output  2  one-cycle read-data-valid pulse, one-hot or zero.
REQ-011 SHALL have port rdata  output  DATA_W  shared read data, qualified by rvalid.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have ports ram_en, ram_we (output 1), ram_addr (output ADDR_W), ram_wdata (output DATA_W): single-port RAM command, all registered.
REQ-014 SHALL have port ram_rdata  input  DATA_W  RAM read data, valid the cycle after the ram_en cycle.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, RDWAIT.
REQ-016 SHALL sample req only in IDLE; req changes in other states have no effect.
REQ-017 In IDLE with req!=0 at edge T, SHALL register, for winner w: gnt[w]=1, ram_en=1, ram_we=we[w], ram_addr/ram_wdata = w's fields; next state ACCESS.
REQ-018 SHALL keep gnt and ram_en high exactly one cycle (the ACCESS cycle), then drive both 0.
REQ-019 ACCESS SHALL go to IDLE for writes and RDWAIT for reads.
REQ-020 RDWAIT SHALL latch ram_rdata into rdata, pulse rvalid[w] one cycle, then return to IDLE.
REQ-021 Latency: gnt/ram_en one cycle after req sampled; rvalid three cycles after req sampled; write occupancy 2 cycles, read occupancy 3 cycles.
REQ-022 rdata SHALL hold its last value between reads; ram_addr/ram_wdata SHALL hold last values while ram_en=0.
REQ-023 Single requester active SHALL always win, regardless of history.
REQ-024 Both requesting in IDLE SHALL be resolved per REQ-030/031.
REQ-025 Requester SHALL hold req/we/addr/wdata stable until gnt; req still high in the IDLE cycle after completion is treated as a new request.
REQ-026 req deasserted before being sampled in IDLE SHALL cause no RAM access.

Reset
REQ-027 reset at any edge SHALL force IDLE and gnt=0, rvalid=0, rdata=0, busy=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, priority pointer to requester 0.
REQ-028 reset during ACCESS or RDWAIT SHALL abort the transaction; no rvalid issued for it.
REQ-029 reset SHALL take priority over all simultaneous requests.

Configuration
REQ-030 With macro ARB_ROUND_ROBIN_EN defined, ties SHALL go to the requester not served last (pointer updated on every grant; after reset requester 0 wins first tie).
REQ-031 Without ARB_ROUND_ROBIN_EN, ties SHALL always go to requester 0 and no pointer register SHALL exist.

Verification
REQ-032 Write: req=01, we=01, addr0=8'h12, wdata0=8'hA5 -> next cycle gnt=01, ram_en=1, ram_we=1, ram_addr=12, ram_wdata=A5; busy low again 2 cycles after sample.
REQ-033 Read-back: req=10, we=00, addr1=8'h12 after REQ-032 write -> rvalid=10 with rdata=8'hA5 three cycles after sample.
REQ-034 Tie, round robin: req=11 held continuously, both reads -> grants alternate 01,10,01,10; fixed-priority build -> grants 01 every time.
REQ-035 Reset mid-read: assert reset in RDWAIT -> next cycle all outputs 0, no rvalid; next req=11 grants 01.
REQ-036 Random soak: 2000 cycles of random req/we/addr/wdata at 12 MHz clk against a reference memory model -> every read rdata matches model, gnt/rvalid never multi-hot.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter in front of a single-port synchronous RAM.
// A request is sampled only while idle; the winner gets a one-cycle grant that
// coincides with a one-cycle RAM command. Writes finish in the ACCESS cycle.
// Reads wait one more cycle for the RAM data, which is captured into rdata
// together with a one-cycle rvalid pulse to the owner.
// Optional feature macro: ARB_ROUND_ROBIN_EN. When it is defined, a tie goes to
// the requester that was not granted last. When it is undefined, a tie always
// goes to requester 0 and there is no pointer register.
module ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req,
    input  logic [1:0]            we,
    input  logic [2*ADDR_W-1:0]   addr,
    input  logic [2*DATA_W-1:0]   wdata,
    output logic [1:0]            gnt,
    output logic [1:0]            rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  busy,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_owner;
    logic [1:0]          r_gnt;
    logic [1:0]          r_rvalid;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_busy;
    logic                r_ram_en;
    logic                r_ram_we;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_wdata;

    // Per-requester views of the packed address and write-data buses.
    logic [ADDR_W-1:0]   w_addr_arr  [2];
    logic [DATA_W-1:0]   w_wdata_arr [2];
    logic                w_winner;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fields
            assign w_addr_arr[gi]  = addr[gi*ADDR_W +: ADDR_W];
            assign w_wdata_arr[gi] = wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

`ifdef ARB_ROUND_ROBIN_EN
    // Requester favoured on the next tie; it is always the one not granted last.
    logic r_prio;

    // Choose the winner: a lone requester always wins, a tie follows the pointer.
    always_comb begin
        w_winner = 1'b0;
        case (req)
            2'b10:   w_winner = 1'b1;
            2'b11:   w_winner = r_prio;
            default: w_winner = 1'b0;
        endcase
    end

    // Move the pointer away from whichever requester has just been granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio <= 1'b0;
        end else if (r_state == IDLE && req != 2'b00) begin
            r_prio <= ~w_winner;
        end
    end
`else
    // Choose the winner: a lone requester always wins, a tie goes to requester 0.
    always_comb begin
        w_winner = 1'b0;
        if (req == 2'b10) begin
            w_winner = 1'b1;
        end
    end
`endif

    // Transaction sequencer with every output registered. Pulses default low, and
    // the RAM address/data and read data hold until they are next loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_owner     <= 1'b0;
            r_gnt       <= 2'b00;
            r_rvalid    <= 2'b00;
            r_rdata     <= '0;
            r_busy      <= 1'b0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            r_gnt    <= 2'b00;
            r_rvalid <= 2'b00;
            r_ram_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req != 2'b00) begin
                        r_gnt       <= 2'b01 << w_winner;
                        r_ram_en    <= 1'b1;
                        r_ram_we    <= we[w_winner];
                        r_ram_addr  <= w_addr_arr[w_winner];
                        r_ram_wdata <= w_wdata_arr[w_winner];
                        r_owner     <= w_winner;
                        r_busy      <= 1'b1;
                        r_state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // The RAM takes the command at this edge; a write is finished.
                    if (r_ram_we) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_state <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    // RAM data is valid in this cycle; capture it for the owner.
                    r_rdata  <= ram_rdata;
                    r_rvalid <= 2'b01 << r_owner;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign rvalid    = r_rvalid;
    assign rdata     = r_rdata;
    assign busy      = r_busy;
    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scenarios plus a randomized soak for ram_arbiter.
// A transaction-level model predicts every output in every cycle. It tracks
// the next cycle on which a request can be accepted, the outstanding read and a
// reference memory. A small synchronous RAM stands in for the real memory.
`timescale 1ns/1ps
module tb_ram_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      req, we;
    logic [2*AW-1:0] addr;
    logic [2*DW-1:0] wdata;
    logic [1:0]      gnt, rvalid;
    logic [DW-1:0]   rdata;
    logic            busy, ram_en, ram_we;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wdata;
    logic [DW-1:0]   ram_rdata;

    int n_pass  = 0;
    int n_total = 0;

    // 12 MHz clock.
    always #41.667 clk = ~clk;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .busy      (busy),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Stand-in single-port synchronous RAM.
    logic [DW-1:0] ram_mem [256];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [DW-1:0] ref_mem [256];
    int            k       = 0;   // index of the most recent rising edge
    int            free_at = 0;   // first edge at which a request can be accepted
    bit            rd_pend = 0;
    int            rd_at   = 0;
    logic [1:0]    rd_w    = 0;
    logic [DW-1:0] rd_data = 0;
    bit            m_prio  = 0;
    logic [1:0]    e_gnt = 0, e_rv = 0;
    logic          e_busy = 0, e_en = 0, e_we = 0;
    logic [AW-1:0] e_addr = 0;
    logic [DW-1:0] e_wdata = 0, e_rdata = 0;

    function automatic int pick(input logic [1:0] r, input bit prio);
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
`ifdef ARB_ROUND_ROBIN_EN
        return int'(prio);
`else
        return 0;
`endif
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            k++;
            if (reset) begin
                e_gnt = 0; e_rv = 0; e_busy = 0; e_en = 0; e_we = 0;
                e_addr = 0; e_wdata = 0; e_rdata = 0;
                rd_pend = 0; m_prio = 0;
                free_at = k + 1;
            end else begin
                e_gnt = 0; e_rv = 0; e_en = 0;
                if (rd_pend && k == rd_at) begin
                    e_rv = rd_w; e_rdata = rd_data; rd_pend = 0;
                end
                if (k >= free_at && req != 2'b00) begin
                    int w;
                    w       = pick(req, m_prio);
                    m_prio  = (w == 0);
                    e_gnt   = 2'(1 << w);
                    e_en    = 1;
                    e_we    = we[w];
                    e_addr  = addr[w*AW +: AW];
                    e_wdata = wdata[w*DW +: DW];
                    if (we[w]) begin
                        ref_mem[e_addr] = e_wdata;
                        free_at = k + 2;
                    end else begin
                        rd_pend = 1; rd_at = k + 2; rd_w = e_gnt;
                        rd_data = ref_mem[e_addr];
                        free_at = k + 3;
                    end
                end
                // Busy in every cycle that comes before the idle cycle which precedes free_at.
                e_busy = (k + 1 < free_at);
            end
        end
    end

    // Compare process: every output against the model in every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (k > 0) begin
                check("m_gnt", gnt, e_gnt);
                check("m_rvalid", rvalid, e_rv);
                check("m_busy", busy, e_busy);
                check("m_ram_en", ram_en, e_en);
                if (e_en) check("m_ram_we", ram_we, e_we);
                check("m_ram_addr", ram_addr, e_addr);
                check("m_ram_wdata", ram_wdata, e_wdata);
                check("m_rdata", rdata, e_rdata);
                check("gnt_onehot", 32'($countones(gnt) <= 1), 1);
                check("rvalid_onehot", 32'($countones(rvalid) <= 1), 1);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_gnt(input string name, output logic [1:0] g);
        g = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt != 0) begin g = gnt; return; end
        end
        check({name, "_timeout"}, 0, 1);
    endtask

    logic [1:0] tie_exp [4];
    logic [1:0] g;
    bit   [1:0] pend;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 0;
            ref_mem[i] = 0;
        end
`ifdef ARB_ROUND_ROBIN_EN
        tie_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        tie_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        reset = 1; req = 0; we = 0; addr = 0; wdata = 0;
        repeat (3) @(negedge clk);
        check("rst_gnt", gnt, 0);        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);    check("rst_busy", busy, 0);
        check("rst_ram_en", ram_en, 0);  check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0); check("rst_ram_wdata", ram_wdata, 0);

        // Write A5 to address 12 from requester 0.
        reset = 0; req = 2'b01; we = 2'b01; addr = 16'h0012; wdata = 16'h00A5;
        @(negedge clk);
        check("wr_gnt", gnt, 2'b01);     check("wr_ram_en", ram_en, 1);
        check("wr_ram_we", ram_we, 1);   check("wr_ram_addr", ram_addr, 8'h12);
        check("wr_ram_wdata", ram_wdata, 8'hA5); check("wr_busy", busy, 1);
        req = 0; we = 0;
        @(negedge clk);
        check("wr_busy_low", busy, 0);   check("wr_gnt_low", gnt, 0);
        check("wr_addr_hold", ram_addr, 8'h12);

        // Read it back from requester 1.
        req = 2'b10; addr = 16'h1200;
        @(negedge clk);
        check("rd_gnt", gnt, 2'b10);     check("rd_ram_we", ram_we, 0);
        check("rd_ram_addr", ram_addr, 8'h12);
        req = 0;
        @(negedge clk);
        check("rd_wait_busy", busy, 1);  check("rd_wait_rvalid", rvalid, 0);
        @(negedge clk);
        check("rd_rvalid", rvalid, 2'b10); check("rd_rdata", rdata, 8'hA5);
        check("rd_busy_low", busy, 0);

        // Held tie, both reads.
        req = 2'b11; we = 0; addr = 16'h1212;
        for (int n = 0; n < 4; n++) begin
            wait_gnt("tie", g);
            check($sformatf("tie_gnt%0d", n), g, tie_exp[n]);
        end
        req = 0;
        repeat (4) @(negedge clk);

        // Reset while the read waits for RAM data.
        req = 2'b01; we = 0; addr = 16'h0012;
        wait_gnt("mid_rd", g);
        req = 0;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        check("mrst_gnt", gnt, 0);       check("mrst_rvalid", rvalid, 0);
        check("mrst_rdata", rdata, 0);   check("mrst_busy", busy, 0);
        check("mrst_ram_en", ram_en, 0); check("mrst_ram_addr", ram_addr, 0);
        reset = 0; req = 2'b11; we = 0;
        @(negedge clk);
        check("mrst_tie_gnt", gnt, 2'b01);
        req = 0;
        repeat (4) @(negedge clk);

        // Random soak: each requester keeps its fields stable until granted.
        pend = 0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (pend[i] && gnt[i]) pend[i] = 0;
                if (!pend[i]) begin
                    if ($urandom % 4 == 0) begin
                        pend[i] = 1;
                        we[i] = 1'($urandom);
                        addr[i*AW +: AW] = AW'($urandom % 16);
                        wdata[i*DW +: DW] = DW'($urandom);
                    end
                end else if ($urandom % 50 == 0) begin
                    pend[i] = 0;
                end
            end
            req = pend;
            reset = ($urandom % 150 == 0);
            @(negedge clk);
        end
        reset = 0; req = 0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
